// File: rtl/rdyack_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rdyack_rr_arbiter_pkg
// Shared types and helpers for the rdy/ack round-robin arbiter family.
//   arb_state_e : arbiter control state, 2-bit encoded. HOLD exists only when
//                 ARB_BURST_EN is defined.
//   arb_iw()    : index width for N requesters (at least 1 bit).
// Optional feature macro: ARB_BURST_EN (burst grants via a HOLD state).
// -----------------------------------------------------------------------------
package rdyack_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOCK = 2'd1
`ifdef ARB_BURST_EN
      ,
      HOLD = 2'd2
`endif
   } arb_state_e;

   // A single requester still needs a 1-bit index so ports never collapse
   // to zero width.
   function automatic int arb_iw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rdyack_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-and-find-first. Scans req starting at ptr, wrapping
// past N-1 back to 0, and returns the first set index. With no request set
// the index falls back to ptr so the grant output stays stable.
// Ports:
//   req [N]  : request vector
//   ptr [IW] : index with highest priority this cycle (always < N)
//   idx [IW] : selected index
//   any      : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
   import rdyack_rr_arbiter_pkg::*;
#(
   parameter int N = 2,
   localparam int IW = arb_iw(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          any
);

   always_comb begin
      int   j;
      logic found;
      j     = 0;
      found = 1'b0;
      idx   = ptr;
      for (int k = 0; k < N; k++) begin
         // Rotated position, kept in 0..N-1 without a modulo operator.
         j = int'(ptr) + k;
         if (j >= N) begin
            j = j - N;
         end
         if (!found && req[j]) begin
            idx   = IW'(j);
            found = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/rdyack_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rdyack_rr_arbiter
// Shares one downstream rdy/ack channel among N upstream requesters with
// round-robin priority. A requester that is offered but not acked is locked
// in until its ack, so the downstream side sees a stable transfer.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   src_rdys [N]   : per-requester rdy, held until its ack
//   src_acks [N]   : per-requester ack, one-hot on dst_ack, else zero
//   dst_rdy        : downstream rdy (0-cycle path from src_rdys)
//   dst_ack        : downstream ack, only while dst_rdy is high
//   o_gnt_idx [IW] : index currently granted
//   o_locked       : high while in LOCK
// Optional feature macro: ARB_BURST_EN. When defined, a requester may keep
// the grant for up to BURST consecutive transfers; a one-cycle HOLD state
// after each ack decides whether the burst continues.
// -----------------------------------------------------------------------------
module rdyack_rr_arbiter
   import rdyack_rr_arbiter_pkg::*;
#(
   parameter int N     = 2,
   parameter int BURST = 4,
   localparam int IW   = arb_iw(N)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [N-1:0]  src_rdys,
   output logic [N-1:0]  src_acks,
   output logic          dst_rdy,
   input  logic          dst_ack,
   output logic [IW-1:0] o_gnt_idx,
   output logic          o_locked
);

   if (N < 1 || BURST < 1) begin : g_bad_params
      $error("rdyack_rr_arbiter: N and BURST must both be >= 1");
   end

   arb_state_e    state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] lock_idx_q, lock_idx_d;
   logic [IW-1:0] pick_idx;
   logic          pick_any;
   logic [IW-1:0] gnt;

   // Next index after i, wrapping N-1 to 0 so ptr never reaches N.
   function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
      if (int'(i) >= N - 1) begin
         return '0;
      end
      return i + 1'b1;
   endfunction

   rr_pick #(.N(N)) u_pick (
      .req (src_rdys),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

`ifdef ARB_BURST_EN
   localparam int BW = arb_iw(BURST);
   logic [BW-1:0] burst_cnt_q, burst_cnt_d;
   logic          burst_more;

   // The locked requester is still asking and has burst budget left.
   assign burst_more = src_rdys[lock_idx_q] && (int'(burst_cnt_q) < BURST - 1);
`endif

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         lock_idx_q  <= '0;
`ifdef ARB_BURST_EN
         burst_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         lock_idx_q  <= lock_idx_d;
`ifdef ARB_BURST_EN
         burst_cnt_q <= burst_cnt_d;
`endif
      end
   end

   // Output logic
   always_comb begin
      gnt     = pick_idx;
      dst_rdy = pick_any;
      case (state_q)
         LOCK: begin
            gnt     = lock_idx_q;
            dst_rdy = src_rdys[lock_idx_q];
         end
`ifdef ARB_BURST_EN
         HOLD: begin
            // A HOLD cycle that will end the burst offers nothing downstream,
            // otherwise the grant could exceed BURST transfers.
            gnt     = lock_idx_q;
            dst_rdy = burst_more;
         end
`endif
         default: ;
      endcase
      src_acks = '0;
      if (dst_ack) begin
         src_acks[gnt] = 1'b1;
      end
   end

   assign o_gnt_idx = gnt;
   assign o_locked  = (state_q == LOCK);

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      lock_idx_d  = lock_idx_q;
`ifdef ARB_BURST_EN
      burst_cnt_d = burst_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (dst_ack) begin
`ifdef ARB_BURST_EN
               lock_idx_d = gnt;
               state_d    = HOLD;
`else
               ptr_d      = inc_idx(gnt);
`endif
            end else if (dst_rdy) begin
               lock_idx_d = gnt;
               state_d    = LOCK;
            end
         end
         LOCK: begin
            if (dst_ack) begin
`ifdef ARB_BURST_EN
               state_d = HOLD;
`else
               ptr_d   = inc_idx(lock_idx_q);
               state_d = IDLE;
`endif
            end
         end
`ifdef ARB_BURST_EN
         HOLD: begin
            if (burst_more) begin
               // Burst continues: an ack right now is the next transfer and
               // needs another decision cycle, otherwise wait in LOCK.
               burst_cnt_d = burst_cnt_q + 1'b1;
               state_d     = dst_ack ? HOLD : LOCK;
            end else begin
               ptr_d       = inc_idx(lock_idx_q);
               burst_cnt_d = '0;
               state_d     = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

endmodule
